dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 256×8 data memory between the CPU core (load/store path) and a host port (test/boot loader that preloads operands before `start` and reads results after `done`). Arbitration is round-robin. A requester can lock the memory for a bounded burst. Write data, address and write-enable are muxed to the memory in the grant cycle. Read data returns one cycle later with a per-port valid.

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing a single-port data memory between
// the CPU core (port 0) and the host loader (port 1). A port may lock the
// memory for a burst bounded by MAX_BURST whenever the other port is waiting.
module dmem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          core_req,
   input  logic          core_we,
   input  logic          core_lock,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic          host_lock,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          core_gnt,
   output logic          host_gnt,
   output logic          core_rvalid,
   output logic          host_rvalid,
   output logic [DW-1:0] core_rdata,
   output logic [DW-1:0] host_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

   localparam logic [3:0] MAXB = 4'(MAX_BURST);

   owner_t     owner, owner_nx;
   logic [3:0] burst_cnt, cnt_nx;
   logic       last, last_nx;   // 0 = core, 1 = host

   // Grant decision: owner keeps the memory until its burst budget runs out
   // while the other port waits; otherwise plain round-robin on 'last'.
   always_comb begin
      core_gnt = 1'b0;
      host_gnt = 1'b0;
      if (rst_n) begin
         if (owner == OWN_CORE && core_req) begin
            if (!host_req || burst_cnt < MAXB) core_gnt = 1'b1;
            else                                host_gnt = 1'b1;
         end else if (owner == OWN_HOST && host_req) begin
            if (!core_req || burst_cnt < MAXB) host_gnt = 1'b1;
            else                                core_gnt = 1'b1;
         end else if (core_req && host_req) begin
            if (last) core_gnt = 1'b1;
            else      host_gnt = 1'b1;
         end else begin
            core_gnt = core_req;
            host_gnt = host_req;
         end
      end
   end

   // Memory mux: host values only when host is granted, core values otherwise.
   always_comb begin
      mem_addr  = host_gnt ? host_addr  : core_addr;
      mem_wdata = host_gnt ? host_wdata : core_wdata;
      mem_we    = (core_gnt & core_we) | (host_gnt & host_we);
   end

   assign core_rdata = mem_rdata;
   assign host_rdata = mem_rdata;

   // Ownership / burst next state. A forced release needs no special case:
   // the new grantee is never the current owner, so it restarts at 1 or clears.
   always_comb begin
      owner_nx = owner;
      cnt_nx   = burst_cnt;
      last_nx  = last;
      if (core_gnt || host_gnt) begin
         last_nx = host_gnt;
         if (host_gnt ? host_lock : core_lock) begin
            if (owner == (host_gnt ? OWN_HOST : OWN_CORE)) begin
               cnt_nx = (burst_cnt < MAXB) ? burst_cnt + 4'd1 : burst_cnt;
            end else begin
               owner_nx = host_gnt ? OWN_HOST : OWN_CORE;
               cnt_nx   = 4'd1;
            end
         end else begin
            owner_nx = OWN_NONE;
            cnt_nx   = 4'd0;
         end
      end else if (owner != OWN_NONE) begin
         // no grant means nobody requests, so the owner has dropped req
         owner_nx = OWN_NONE;
         cnt_nx   = 4'd0;
      end
   end

   // State registers and read-valid flops; reset drops any pending rvalid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner       <= OWN_NONE;
         burst_cnt   <= 4'd0;
         last        <= 1'b1;
         core_rvalid <= 1'b0;
         host_rvalid <= 1'b0;
      end else begin
         owner       <= owner_nx;
         burst_cnt   <= cnt_nx;
         last        <= last_nx;
         core_rvalid <= core_gnt & ~core_we;
         host_rvalid <= host_gnt & ~host_we;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench. Expected grants are written per cycle,
// expected read data comes from a bench-side shadow of memory contents.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       core_req = 0, core_we = 0, core_lock = 0;
   logic       host_req = 0, host_we = 0, host_lock = 0;
   logic [7:0] core_addr = 0, core_wdata = 0, host_addr = 0, host_wdata = 0;
   logic       core_gnt, host_gnt, core_rvalid, host_rvalid, mem_we;
   logic [7:0] core_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_mem [256];
   logic [7:0] core_q[$];
   logic [7:0] host_q[$];
   logic       pend_c = 0, pend_h = 0;

   dmem_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_lock(core_lock),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .core_gnt(core_gnt), .host_gnt(host_gnt),
      .core_rvalid(core_rvalid), .host_rvalid(host_rvalid),
      .core_rdata(core_rdata), .host_rdata(host_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Write-first synchronous RAM; unwritten cells read as addr ^ 0x5A.
   bit [7:0] ram [256];
   bit       wr  [256];
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
         wr[mem_addr]  <= 1'b1;
         mem_rdata     <= mem_wdata;
      end else begin
         mem_rdata <= wr[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'h5A);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive, check at negedge, schedule expected reads.
   // eg = {host_gnt, core_gnt} expected; rf = pull reset low before the edge.
   task automatic cyc(input logic cr, input logic cw, input logic cl,
                      input logic [7:0] ca, input logic [7:0] cd,
                      input logic hr, input logic hw, input logic hl,
                      input logic [7:0] ha, input logic [7:0] hd,
                      input logic [1:0] eg, input logic rf);
      core_req = cr; core_we = cw; core_lock = cl; core_addr = ca; core_wdata = cd;
      host_req = hr; host_we = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
      @(negedge clk);
      chk("gnt", {host_gnt, core_gnt}, eg);
      chk("mem_we", mem_we, (eg[0] & cw) | (eg[1] & hw));
      if (eg[0]) chk("mem_addr_c", mem_addr, ca);
      if (eg[1]) chk("mem_addr_h", mem_addr, ha);
      if (eg[1] && hw) chk("mem_wdata_h", mem_wdata, hd);
      chk("core_rvalid", core_rvalid, pend_c);
      chk("host_rvalid", host_rvalid, pend_h);
      if (pend_c && core_q.size() > 0) chk("core_rdata", core_rdata, core_q.pop_front());
      if (pend_h && host_q.size() > 0) chk("host_rdata", host_rdata, host_q.pop_front());
      pend_c = eg[0] && !cw && !rf;
      pend_h = eg[1] && !hw && !rf;
      if (pend_c) core_q.push_back(ref_mem[ca]);
      if (pend_h) host_q.push_back(ref_mem[ha]);
      if (eg[0] && cw && !rf) ref_mem[ca] = cd;
      if (eg[1] && hw && !rf) ref_mem[ha] = hd;
      if (rf) rst_n = 1'b0;
      @(posedge clk);
      #1;
      if (rf) rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

      // reset with both ports requesting
      repeat (2) cyc(1,0,0,8'h01,0, 1,0,0,8'h02,0, 2'b00, 0);
      rst_n = 1'b1;

      // host write then read back, then an idle drain cycle
      cyc(0,0,0,0,0, 1,1,0,8'h10,8'hA5, 2'b10, 0);
      cyc(0,0,0,0,0, 1,0,0,8'h10,0,     2'b10, 0);
      cyc(0,0,0,0,0, 0,0,0,0,0,         2'b00, 0);

      // round robin, back-to-back reads, core first
      for (int i = 0; i < 2; i++) begin
         cyc(1,0,0,8'h20,0, 1,0,0,8'h10,0, 2'b01, 0);
         cyc(1,0,0,8'h20,0, 1,0,0,8'h10,0, 2'b10, 0);
      end

      // locked burst: 4 core, forced host, core regains with count 1
      for (int i = 0; i < 4; i++) cyc(1,0,1,8'h40,0, 1,0,0,8'h41,0, 2'b01, 0);
      cyc(1,0,1,8'h40,0, 1,0,0,8'h41,0, 2'b10, 0);
      cyc(1,0,1,8'h40,0, 1,0,0,8'h41,0, 2'b01, 0);
      chk("burst_restart", 32'(dut.burst_cnt), 1);

      // lock release: second locked cycle, then core drops req
      cyc(1,0,1,8'h40,0, 1,0,0,8'h41,0, 2'b01, 0);
      cyc(0,0,0,8'h40,0, 1,0,0,8'h41,0, 2'b10, 0);
      chk("owner_none", 32'(dut.owner), 0);

      // lone locked core saturates its count, host then forces release at once
      repeat (6) cyc(1,0,1,8'h50,0, 0,0,0,0,0, 2'b01, 0);
      chk("burst_sat", 32'(dut.burst_cnt), 4);
      cyc(1,0,1,8'h50,0, 1,0,0,8'h51,0, 2'b10, 0);
      cyc(0,0,0,0,0, 0,0,0,0,0, 2'b00, 0);

      // core read-after-write on consecutive grants
      cyc(1,1,0,8'h33,8'h3C, 0,0,0,0,0, 2'b01, 0);
      cyc(1,0,0,8'h33,0,     0,0,0,0,0, 2'b01, 0);

      // reset mid-read: rvalid dropped, first tie goes to core
      cyc(1,0,0,8'h33,0, 0,0,0,0,0, 2'b01, 1);
      cyc(1,0,0,8'h20,0, 1,0,0,8'h21,0, 2'b01, 0);
      cyc(0,0,0,0,0, 0,0,0,0,0, 2'b00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
